bram_arbiter: RTL and testbench

- Round-robin arbiter that shares one cleared block RAM (`BRAM_clear`) between NUM_PORTS requesters.
- Each requester sees the same request/rw/address/wdata/rdata/ready handshake as a private BRAM.
- The arbiter serialises accesses, routes read data and ready back to the winner, and holds off all traffic until the RAM reports its clear sequence has finished.
- Sits between CPU/DMA/video masters and a shared scratch or tag memory.

---
 rtl/bram_arbiter.sv | 126 ++++++++++++
 tb/tb_bram_arbiter.sv | 265 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/bram_arbiter.sv
// Round-robin arbiter sharing one cleared block RAM between NUM_PORTS requesters.
// Each requester sees a private-BRAM style request/ready handshake. Accesses are
// serialised as IDLE -> ACTIVE -> RELEASE, and nothing is granted until the RAM
// reports that its clear sequence has finished.
//
// Handshake: a requester raises i_request[n] (with i_rw/i_address/i_wdata stable)
// and holds it until it sees o_ready[n] for one cycle; o_rdata is valid in that
// cycle and holds until the next completion. Downstream, o_bram_request is held
// until i_bram_ready is seen high.
module bram_arbiter #(
    parameter int NUM_PORTS = 3,
    parameter int WIDTH     = 32,
    parameter int PORT_BITS = $clog2(NUM_PORTS)
) (
    input  logic                       i_clock,
    input  logic                       i_reset,
    input  logic [NUM_PORTS-1:0]       i_request,
    input  logic [NUM_PORTS-1:0]       i_rw,
    input  logic [32*NUM_PORTS-1:0]    i_address,
    input  logic [WIDTH*NUM_PORTS-1:0] i_wdata,
    output logic [WIDTH-1:0]           o_rdata,
    output logic [NUM_PORTS-1:0]       o_ready,
    output logic                       o_bram_request,
    output logic                       o_bram_rw,
    output logic [31:0]                o_bram_address,
    output logic [WIDTH-1:0]           o_bram_wdata,
    input  logic [WIDTH-1:0]           i_bram_rdata,
    input  logic                       i_bram_ready,
    input  logic                       i_bram_initialized,
    output logic [1:0]                 o_debug_state
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ACTIVE  = 2'd1,
        RELEASE = 2'd2
    } state_t;

    state_t                 state;
    logic [PORT_BITS-1:0]   grant;
    logic [PORT_BITS-1:0]   last_grant;
    logic [PORT_BITS-1:0]   next_grant;
    logic [PORT_BITS-1:0]   candidate;
    logic                   any_request;
    logic [NUM_PORTS-1:0]   grant_onehot;

    assign o_debug_state = state;

    // Round-robin scan starting just after the last served port.
    always_comb begin
        next_grant  = last_grant;
        any_request = 1'b0;
        candidate   = '0;
        for (int i = 1; i <= NUM_PORTS; i++) begin
            candidate = PORT_BITS'((int'(last_grant) + i) % NUM_PORTS);
            if (!any_request && i_request[candidate]) begin
                any_request = 1'b1;
                next_grant  = candidate;
            end
        end
    end

    // One-hot form of the current grant, used for the completion pulse.
    always_comb begin
        grant_onehot        = '0;
        grant_onehot[grant] = 1'b1;
    end

    // Downstream mux: the granted port drives the RAM only while ACTIVE.
    always_comb begin
        o_bram_request = (state == ACTIVE);
        o_bram_rw      = 1'b0;
        o_bram_address = '0;
        o_bram_wdata   = '0;
        if (state == ACTIVE) begin
            for (int p = 0; p < NUM_PORTS; p++) begin
                if (grant == PORT_BITS'(p)) begin
                    o_bram_rw      = i_rw[p];
                    o_bram_address = i_address[32*p +: 32];
                    o_bram_wdata   = i_wdata[WIDTH*p +: WIDTH];
                end
            end
        end
    end

    // Arbitration FSM with registered completion pulse and read data.
    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            state      <= IDLE;
            grant      <= '0;
            last_grant <= PORT_BITS'(NUM_PORTS - 1);
            o_ready    <= '0;
            o_rdata    <= '0;
        end else begin
            o_ready <= '0;
            case (state)
                IDLE: begin
                    if (i_bram_initialized && any_request) begin
                        grant <= next_grant;
                        state <= ACTIVE;
                    end
                end
                ACTIVE: begin
                    // A falling initialized flag means the RAM restarted its clear:
                    // abandon the access silently and re-arbitrate later.
                    if (!i_bram_initialized) begin
                        state <= IDLE;
                    end else if (i_bram_ready) begin
                        o_rdata    <= i_bram_rdata;
                        o_ready    <= grant_onehot;
                        last_grant <= grant;
                        state      <= RELEASE;
                    end
                end
                RELEASE: begin
                    // Requests ignored here so the winner can drop its request.
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_bram_arbiter.sv
// Directed bench for bram_arbiter with a 1-cycle cleared RAM model behind it.
module tb_bram_arbiter;

    localparam int N = 3;
    localparam int W = 32;

    logic             i_clock = 1'b0;
    logic             i_reset;
    logic [N-1:0]     i_request;
    logic [N-1:0]     i_rw;
    logic [32*N-1:0]  i_address;
    logic [W*N-1:0]   i_wdata;
    logic [W-1:0]     o_rdata;
    logic [N-1:0]     o_ready;
    logic             o_bram_request;
    logic             o_bram_rw;
    logic [31:0]      o_bram_address;
    logic [W-1:0]     o_bram_wdata;
    logic [W-1:0]     i_bram_rdata;
    logic             i_bram_ready;
    logic             i_bram_initialized;
    logic [1:0]       o_debug_state;

    int total = 0;
    int bad   = 0;

    bram_arbiter #(.NUM_PORTS(N), .WIDTH(W)) dut (
        .i_clock            (i_clock),
        .i_reset            (i_reset),
        .i_request          (i_request),
        .i_rw               (i_rw),
        .i_address          (i_address),
        .i_wdata            (i_wdata),
        .o_rdata            (o_rdata),
        .o_ready            (o_ready),
        .o_bram_request     (o_bram_request),
        .o_bram_rw          (o_bram_rw),
        .o_bram_address     (o_bram_address),
        .o_bram_wdata       (o_bram_wdata),
        .i_bram_rdata       (i_bram_rdata),
        .i_bram_ready       (i_bram_ready),
        .i_bram_initialized (i_bram_initialized),
        .o_debug_state      (o_debug_state)
    );

    always #5 i_clock = ~i_clock;

    // RAM model: cleared to zero while not initialized, one-cycle ready pulse
    // per request, read-before-write data.
    logic [W-1:0] mem [256];
    always @(posedge i_clock) begin
        if (!i_bram_initialized) begin
            for (int k = 0; k < 256; k++) mem[k] <= '0;
            i_bram_ready <= 1'b0;
            i_bram_rdata <= '0;
        end else begin
            i_bram_ready <= o_bram_request & ~i_bram_ready;
            if (o_bram_request && o_bram_rw) mem[o_bram_address[9:2]] <= o_bram_wdata;
            i_bram_rdata <= mem[o_bram_address[9:2]];
        end
    end

    task automatic step();
        @(posedge i_clock);
        #1;
    endtask

    task automatic check(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    // Steps until a completion pulse appears or the budget runs out; n is the
    // number of clock edges taken. A timeout shows up in the caller's o_ready check.
    task automatic wait_ready(input int max, output int n);
        n = 0;
        do begin
            step();
            n++;
        end while (o_ready == '0 && n < max);
    endtask

    task automatic set_port(input int p, input logic rw, input logic [31:0] addr, input logic [W-1:0] wd);
        i_rw[p]              = rw;
        i_address[32*p +: 32] = addr;
        i_wdata[W*p +: W]     = wd;
    endtask

    initial begin
        int   n;
        logic saw;

        i_reset            = 1'b1;
        i_request          = '0;
        i_rw               = '0;
        i_address          = '0;
        i_wdata            = '0;
        i_bram_initialized = 1'b0;
        repeat (3) step();
        i_reset = 1'b0;
        step();

        // Reset state
        check("rst_ready",   32'(o_ready), 32'h0);
        check("rst_rdata",   o_rdata, 32'h0);
        check("rst_breq",    32'(o_bram_request), 32'h0);
        check("rst_state",   32'(o_debug_state), 32'h0);

        // Port 0 requests while the RAM is still clearing
        set_port(0, 1'b0, 32'h20, 32'h0);
        i_request[0] = 1'b1;
        saw = 1'b0;
        for (int c = 0; c < 1024; c++) begin
            step();
            saw = saw | o_bram_request | (|o_ready);
        end
        check("uninit_quiet", 32'(saw), 32'h0);
        i_bram_initialized = 1'b1;
        step();
        check("p0_breq_c1",  32'(o_bram_request), 32'h1);
        check("p0_baddr",    o_bram_address, 32'h20);
        check("p0_brw",      32'(o_bram_rw), 32'h0);
        step();
        check("p0_breq_c2",  32'(o_bram_request), 32'h1);
        step();
        check("p0_ready_c3", 32'(o_ready), 32'h1);
        check("p0_breq_c3",  32'(o_bram_request), 32'h0);
        check("p0_rdata_clr", o_rdata, 32'h0);
        i_request[0] = 1'b0;
        step();
        check("p0_ready_off", 32'(o_ready), 32'h0);
        check("p0_idle",      32'(o_debug_state), 32'h0);

        // Port 1 writes, then port 2 reads the same word
        set_port(1, 1'b1, 32'h10, 32'hDEADBEEF);
        i_request[1] = 1'b1;
        step();
        check("p1_breq",   32'(o_bram_request), 32'h1);
        check("p1_brw",    32'(o_bram_rw), 32'h1);
        check("p1_baddr",  o_bram_address, 32'h10);
        check("p1_bwdata", o_bram_wdata, 32'hDEADBEEF);
        wait_ready(10, n);
        check("p1_ready",  32'(o_ready), 32'h2);
        i_request[1] = 1'b0;
        set_port(1, 1'b0, 32'h0, 32'h0);
        set_port(2, 1'b0, 32'h10, 32'h0);
        i_request[2] = 1'b1;
        wait_ready(10, n);
        check("p2_ready",  32'(o_ready), 32'h4);
        check("p2_rdata",  o_rdata, 32'hDEADBEEF);
        i_request[2] = 1'b0;
        step();
        check("rdata_hold", o_rdata, 32'hDEADBEEF);

        // Ports 0 and 2 together after port 2 was last served: 0 wins first
        set_port(0, 1'b0, 32'h10, 32'h0);
        set_port(2, 1'b0, 32'h24, 32'h0);
        i_request[0] = 1'b1;
        i_request[2] = 1'b1;
        wait_ready(10, n);
        check("tie_first",  32'(o_ready), 32'h1);
        check("tie_rdata0", o_rdata, 32'hDEADBEEF);
        i_request[0] = 1'b0;
        wait_ready(10, n);
        check("tie_second", 32'(o_ready), 32'h4);
        check("tie_rdata2", o_rdata, 32'h0);
        i_request[2] = 1'b0;

        // All ports write continuously: grants rotate 0,1,2,0,1,2, pulses 4 cycles apart
        set_port(0, 1'b1, 32'h100, 32'hA0A0A0A0);
        set_port(1, 1'b1, 32'h104, 32'hB1B1B1B1);
        set_port(2, 1'b1, 32'h108, 32'hC2C2C2C2);
        i_request = 3'b111;
        for (int g = 0; g < 6; g++) begin
            wait_ready(10, n);
            check($sformatf("rr_grant%0d", g), 32'(o_ready), 32'(1 << (g % 3)));
            // one edge spent on the single-cycle check below plus n edges = 4
            if (g > 0) check($sformatf("rr_gap%0d", g), 32'(n), 32'd3);
            step();
            check($sformatf("rr_single%0d", g), 32'(o_ready), 32'h0);
        end
        i_request = '0;
        i_rw      = '0;

        // Read back port 2's word through port 1
        set_port(1, 1'b0, 32'h108, 32'h0);
        i_request[1] = 1'b1;
        wait_ready(10, n);
        check("rb_ready", 32'(o_ready), 32'h2);
        check("rb_rdata", o_rdata, 32'hC2C2C2C2);
        i_request[1] = 1'b0;

        // RAM restarts its clear mid-access: access dropped, then served afterwards
        set_port(2, 1'b0, 32'h104, 32'h0);
        i_request[2] = 1'b1;
        step();
        step();
        check("drop_breq_on", 32'(o_bram_request), 32'h1);
        i_bram_initialized = 1'b0;
        step();
        check("drop_breq_off", 32'(o_bram_request), 32'h0);
        check("drop_no_ready", 32'(o_ready), 32'h0);
        saw = 1'b0;
        for (int c = 0; c < 5; c++) begin
            step();
            saw = saw | o_bram_request | (|o_ready);
        end
        check("drop_quiet", 32'(saw), 32'h0);
        i_bram_initialized = 1'b1;
        wait_ready(10, n);
        check("drop_served", 32'(o_ready), 32'h4);
        check("drop_rdata",  o_rdata, 32'h0);
        i_request[2] = 1'b0;

        // Serve port 0 so a reset-free restart would favour port 1
        set_port(0, 1'b0, 32'h10, 32'h0);
        i_request[0] = 1'b1;
        wait_ready(10, n);
        check("pre_rst_p0", 32'(o_ready), 32'h1);
        i_request[0] = 1'b0;

        // Reset during port 1's access
        set_port(1, 1'b0, 32'h104, 32'h0);
        i_request[1] = 1'b1;
        step();
        step();
        check("rst_mid_breq", 32'(o_bram_request), 32'h1);
        i_reset            = 1'b1;
        i_bram_initialized = 1'b0;
        i_request[0]       = 1'b1;
        i_request[2]       = 1'b1;
        step();
        i_reset = 1'b0;
        check("rst_mid_ready", 32'(o_ready), 32'h0);
        check("rst_mid_off",   32'(o_bram_request), 32'h0);
        check("rst_mid_state", 32'(o_debug_state), 32'h0);
        saw = 1'b0;
        for (int c = 0; c < 10; c++) begin
            step();
            saw = saw | o_bram_request | (|o_ready);
        end
        check("rst_clear_quiet", 32'(saw), 32'h0);
        i_bram_initialized = 1'b1;
        wait_ready(10, n);
        check("post_rst_p0", 32'(o_ready), 32'h1);
        check("post_rst_rdata", o_rdata, 32'h0);
        i_request[0] = 1'b0;
        wait_ready(10, n);
        check("post_rst_p1", 32'(o_ready), 32'h2);
        i_request[1] = 1'b0;
        wait_ready(10, n);
        check("post_rst_p2", 32'(o_ready), 32'h4);
        i_request[2] = 1'b0;
        step();
        step();
        check("final_idle", 32'(o_debug_state), 32'h0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
